// File: rtl/trx_sequencer.sv
// trx_sequencer: RX/TX switchover sequencer for the transceiver datapath.
// It orders mute -> relay -> transmitter enable -> level ramp on key-down,
// and runs the same sequence in reverse on key-up. The key is the
// synchronised I2C PTT request OR'd with the CW key plus its hang time.
module trx_sequencer #(
    parameter int unsigned MUTE_DELAY  = 50,
    parameter int unsigned RELAY_DELAY = 500,
    parameter int unsigned RAMP_DIV    = 4,
    parameter int unsigned CW_HANG     = 2000
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       ptt_req,
    input  logic       cw_key,
    input  logic [7:0] tx_level_in,
    output logic [7:0] level_out,
    output logic       tx_enable,
    output logic       rx_mute,
    output logic       rf_relay,
    output logic [2:0] state,
    output logic       busy
);

    // State codes are visible on the state port and over I2C readback.
    localparam logic [2:0] S_RX        = 3'd0;
    localparam logic [2:0] S_MUTE      = 3'd1;
    localparam logic [2:0] S_RELAY_ON  = 3'd2;
    localparam logic [2:0] S_RAMP_UP   = 3'd3;
    localparam logic [2:0] S_TX        = 3'd4;
    localparam logic [2:0] S_RAMP_DOWN = 3'd5;
    localparam logic [2:0] S_RELAY_OFF = 3'd6;

    // Dwell loads with delay-1 so that a timed state lasts exactly delay cycles.
    localparam logic [15:0] MUTE_LOAD  = 16'(MUTE_DELAY - 1);
    localparam logic [15:0] RELAY_LOAD = 16'(RELAY_DELAY - 1);
    localparam logic [15:0] STEP_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [15:0] HANG_LOAD  = 16'(CW_HANG);

    logic        ptt_meta_q, ptt_sync_q;
    logic        cw_meta_q, cw_sync_q;
    logic [15:0] hang_q, hang_d;
    logic        cw_hold, key;

    logic [2:0]  state_q, state_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  level_q, level_d;
    logic        mute_q, mute_d;
    logic        relay_q, relay_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;

    logic        dwell_zero;
    logic        stay;
    logic        move;
    logic        move_up;
    logic        fire;

    // Two-flop synchronisers for the asynchronous PTT and CW key inputs.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ptt_meta_q <= 1'b0;
            ptt_sync_q <= 1'b0;
            cw_meta_q  <= 1'b0;
            cw_sync_q  <= 1'b0;
        end else begin
            ptt_meta_q <= ptt_req;
            ptt_sync_q <= ptt_meta_q;
            cw_meta_q  <= cw_key;
            cw_sync_q  <= cw_meta_q;
        end
    end

    // CW hang timer: reloads while the key is held, counts down once released.
    always_comb begin
        hang_d = hang_q;
        if (cw_sync_q) begin
            hang_d = HANG_LOAD;
        end else if (hang_q != '0) begin
            hang_d = hang_q - 16'd1;
        end
    end

    assign cw_hold    = cw_sync_q | (hang_q != '0);
    assign key        = ptt_sync_q | cw_hold;
    assign dwell_zero = (dwell_q == '0);

    // Next-state logic; a released key takes priority over dwell expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RX: begin
                if (key) state_d = S_MUTE;
            end
            S_MUTE: begin
                if (!key)           state_d = S_RX;
                else if (dwell_zero) state_d = S_RELAY_ON;
            end
            S_RELAY_ON: begin
                if (dwell_zero) state_d = key ? S_RAMP_UP : S_RELAY_OFF;
            end
            S_RAMP_UP: begin
                if (!key)                         state_d = S_RAMP_DOWN;
                else if (level_q >= tx_level_in)  state_d = S_TX;
            end
            S_TX: begin
                if (!key) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (key)                 state_d = S_RAMP_UP;
                else if (level_q == '0)  state_d = S_RELAY_OFF;
            end
            S_RELAY_OFF: begin
                if (dwell_zero) state_d = S_RX;
            end
            default: state_d = S_RX;
        endcase
    end

    // Dwell counter: loads on entry to a timed state, counts down while in it.
    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            case (state_d)
                S_MUTE:                  dwell_d = MUTE_LOAD;
                S_RELAY_ON, S_RELAY_OFF: dwell_d = RELAY_LOAD;
                default:                 dwell_d = '0;
            endcase
        end else if (!dwell_zero) begin
            dwell_d = dwell_q - 16'd1;
        end
    end

    // Ramp step timer and level: the timer idles at zero whenever no step is
    // pending, so a level change in TX always takes RAMP_DIV cycles per LSB.
    always_comb begin
        stay    = (state_d == state_q);
        move    = 1'b0;
        move_up = 1'b0;
        case (state_q)
            S_RAMP_UP: begin
                move    = (level_q < tx_level_in);
                move_up = 1'b1;
            end
            S_TX: begin
                move    = (level_q != tx_level_in);
                move_up = (level_q < tx_level_in);
            end
            S_RAMP_DOWN: begin
                move    = (level_q != '0);
                move_up = 1'b0;
            end
            default: begin
                move    = 1'b0;
                move_up = 1'b0;
            end
        endcase

        fire   = 1'b0;
        step_d = '0;
        if (stay && move) begin
            if (step_q >= STEP_LAST) begin
                fire = 1'b1;
            end else begin
                step_d = step_q + 16'd1;
            end
        end

        level_d = level_q;
        if (fire) begin
            level_d = move_up ? (level_q + 8'd1) : (level_q - 8'd1);
        end
        if (!(state_d inside {S_RAMP_UP, S_TX, S_RAMP_DOWN})) begin
            level_d = '0;
        end
    end

    // Output decode from the next state so outputs register alongside state.
    always_comb begin
        mute_d  = (state_d != S_RX);
        relay_d = state_d inside {S_RELAY_ON, S_RAMP_UP, S_TX, S_RAMP_DOWN};
        en_d    = state_d inside {S_RAMP_UP, S_TX, S_RAMP_DOWN};
        busy_d  = (state_d != S_RX) && (state_d != S_TX);
    end

    // Sequencer registers; reset drops relay and enable immediately.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hang_q  <= '0;
            state_q <= S_RX;
            dwell_q <= '0;
            step_q  <= '0;
            level_q <= '0;
            mute_q  <= 1'b0;
            relay_q <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            hang_q  <= hang_d;
            state_q <= state_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            level_q <= level_d;
            mute_q  <= mute_d;
            relay_q <= relay_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign state     = state_q;
    assign level_out = level_q;
    assign rx_mute   = mute_q;
    assign rf_relay  = relay_q;
    assign tx_enable = en_q;
    assign busy      = busy_q;

endmodule
